// File: rtl/bp_fe_be_endpoint_pkg.sv
// bp_fe_pkg: shared types for the FE side of the FE/BE link.
//   - bp_fe_cmd_opcode_e : fe_cmd opcodes (4-7 reserved, treated as pc_redirect)
//   - bp_fe_ep_state_e   : endpoint FSM states
//   - BP_FE_DECLARE_*    : fe_queue entry / fe_cmd structs, sized by the
//                          width parameters of the including module
//   - is_fence_op()      : true for opcodes that wait on fence_done
// No ports.

`define BP_FE_DECLARE_QUEUE_S(vaddr_w, instr_w, meta_w) \
    typedef struct packed { \
        logic                 exception; \
        logic [1:0]           exc_code; \
        logic [(vaddr_w)-1:0] pc; \
        logic [(instr_w)-1:0] instr; \
        logic [(meta_w)-1:0]  metadata; \
    } bp_fe_queue_s;

`define BP_FE_DECLARE_CMD_S(vaddr_w) \
    typedef struct packed { \
        logic [2:0]           opcode; \
        logic [(vaddr_w)-1:0] npc; \
    } bp_fe_cmd_s;

package bp_fe_pkg;

    typedef enum logic [2:0] {
        e_op_state_reset  = 3'd0,
        e_op_pc_redirect  = 3'd1,
        e_op_icache_fence = 3'd2,
        e_op_itlb_fence   = 3'd3
    } bp_fe_cmd_opcode_e;

    typedef enum logic [1:0] {
        e_run      = 2'd0,
        e_redirect = 2'd1,
        e_fence    = 2'd2
    } bp_fe_ep_state_e;

    function automatic logic is_fence_op(input logic [2:0] op);
        return (op == e_op_icache_fence) || (op == e_op_itlb_fence);
    endfunction

endpackage

// File: rtl/bp_fe_be_endpoint_if.sv
// FE/BE endpoint signal bundle. Signal names are seen from the endpoint,
// so _i are endpoint inputs and _o endpoint outputs.
//   slave  : the endpoint (bp_fe_be_endpoint)
//   master : the environment (fetch pipeline + BE)
// Groups: fetch handshake, fe_queue handshake, fe_cmd handshake,
// redirect handshake, fence completion.

interface bp_fe_be_endpoint_if #(
    parameter int vaddr_width_p               = 39,
    parameter int instr_width_p               = 32,
    parameter int branch_metadata_fwd_width_p = 40
);
    localparam int fe_queue_width_lp = 3 + vaddr_width_p + instr_width_p + branch_metadata_fwd_width_p;
    localparam int fe_cmd_width_lp   = 3 + vaddr_width_p;

    logic                                   fetch_v_i;
    logic                                   fetch_ready_o;
    logic                                   fetch_exception_i;
    logic [1:0]                             fetch_exc_code_i;
    logic [vaddr_width_p-1:0]               fetch_pc_i;
    logic [instr_width_p-1:0]               fetch_instr_i;
    logic [branch_metadata_fwd_width_p-1:0] fetch_metadata_i;

    logic [fe_queue_width_lp-1:0]           fe_queue_o;
    logic                                   fe_queue_v_o;
    logic                                   fe_queue_ready_i;

    logic [fe_cmd_width_lp-1:0]             fe_cmd_i;
    logic                                   fe_cmd_v_i;
    logic                                   fe_cmd_yumi_o;

    logic                                   redirect_v_o;
    logic [2:0]                             redirect_opcode_o;
    logic [vaddr_width_p-1:0]               redirect_npc_o;
    logic                                   redirect_ready_i;
    logic                                   fence_done_i;

    modport slave (
        input  fetch_v_i, fetch_exception_i, fetch_exc_code_i, fetch_pc_i,
               fetch_instr_i, fetch_metadata_i, fe_queue_ready_i, fe_cmd_i,
               fe_cmd_v_i, redirect_ready_i, fence_done_i,
        output fetch_ready_o, fe_queue_o, fe_queue_v_o, fe_cmd_yumi_o,
               redirect_v_o, redirect_opcode_o, redirect_npc_o
    );

    modport master (
        output fetch_v_i, fetch_exception_i, fetch_exc_code_i, fetch_pc_i,
               fetch_instr_i, fetch_metadata_i, fe_queue_ready_i, fe_cmd_i,
               fe_cmd_v_i, redirect_ready_i, fence_done_i,
        input  fetch_ready_o, fe_queue_o, fe_queue_v_o, fe_cmd_yumi_o,
               redirect_v_o, redirect_opcode_o, redirect_npc_o
    );

endinterface

// File: rtl/bp_fe_be_endpoint_fifo.sv
// bp_fe_endpoint_fifo: circular 1-read/1-write buffer.
//   clk_i, reset_n_i : clock, async active-low reset (empties the buffer)
//   clr_i            : synchronous flush, wins over v_i/yumi_i
//   v_i, data_i      : write (caller guarantees ~full_o)
//   yumi_i           : pop head (caller guarantees ~empty_o)
//   data_o           : head entry, valid while ~empty_o
//   full_o, empty_o  : occupancy flags

module bp_fe_endpoint_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        wptr_d = wptr_q + ptr_w_lp'(v_i);
        rptr_d = rptr_q + ptr_w_lp'(yumi_i);
        cnt_d  = cnt_q + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == cnt_w_lp'(els_p));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_fe_be_endpoint.sv
// bp_fe_be_endpoint: FE-side terminus of the FE/BE link.
//   clk_i, reset_n_i : clock, async active-low reset
//   fe_be (slave)    : fetch handshake in, fe_queue out toward the BE,
//                      fe_cmd in from the BE with yumi, redirect out to
//                      the fetch pipeline, fence completion in.
// Fetched entries are packed and buffered in a small FIFO. A BE command
// flushes the FIFO, is replayed to the fetch pipeline as a redirect and,
// for fences, waits for fence_done before the one-cycle yumi.

module bp_fe_be_endpoint
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p               = 39,
    parameter int instr_width_p               = 32,
    parameter int branch_metadata_fwd_width_p = 40,
    parameter int fe_queue_els_p              = 4
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    bp_fe_be_endpoint_if.slave  fe_be
);
    `BP_FE_DECLARE_QUEUE_S(vaddr_width_p, instr_width_p, branch_metadata_fwd_width_p)
    `BP_FE_DECLARE_CMD_S(vaddr_width_p)

    localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

    localparam logic [1:0] S_RUN      = e_run;
    localparam logic [1:0] S_REDIRECT = e_redirect;
    localparam logic [1:0] S_FENCE    = e_fence;

    logic [1:0] state_q, state_d;
    bp_fe_cmd_s cmd_q, cmd_d;

    bp_fe_queue_s                 enq_entry;
    logic [fe_queue_width_lp-1:0] head_entry;
    logic full, empty, enq, deq, clr, fetch_ready, yumi, in_run;

    assign in_run = (state_q == S_RUN);

    // Gated by reset so the output reads 0 while reset is held, not just
    // after the first edge. A pending command blocks fetch so the flush
    // never races a same-cycle enqueue. No bypass when full.
    assign fetch_ready = reset_n_i & in_run & ~full & ~fe_be.fe_cmd_v_i;
    assign enq         = fe_be.fetch_v_i & fetch_ready;
    assign deq         = ~empty & fe_be.fe_queue_ready_i;
    assign clr         = in_run & fe_be.fe_cmd_v_i;

    assign enq_entry = '{
        exception: fe_be.fetch_exception_i,
        exc_code:  fe_be.fetch_exc_code_i,
        pc:        fe_be.fetch_pc_i,
        instr:     fe_be.fetch_instr_i,
        metadata:  fe_be.fetch_metadata_i
    };

    bp_fe_endpoint_fifo #(
        .width_p (fe_queue_width_lp),
        .els_p   (fe_queue_els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (clr),
        .v_i       (enq),
        .data_i    (enq_entry),
        .yumi_i    (deq),
        .data_o    (head_entry),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        yumi    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (fe_be.fe_cmd_v_i) begin
                    cmd_d   = fe_be.fe_cmd_i;
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (fe_be.redirect_ready_i) begin
                    if (is_fence_op(cmd_q.opcode)) begin
                        state_d = S_FENCE;
                    end else begin
                        yumi    = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_FENCE: begin
                if (fe_be.fence_done_i) begin
                    yumi    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_RUN;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // FIFO is flushed on command entry, so ~empty already implies e_run.
    assign fe_be.fe_queue_o        = head_entry;
    assign fe_be.fe_queue_v_o      = ~empty;
    assign fe_be.fetch_ready_o     = fetch_ready;
    assign fe_be.fe_cmd_yumi_o     = yumi;
    assign fe_be.redirect_v_o      = (state_q == S_REDIRECT);
    assign fe_be.redirect_opcode_o = cmd_q.opcode;
    assign fe_be.redirect_npc_o    = cmd_q.npc;

    // The BE must hold fe_cmd_v_i until yumi; the block completes from
    // cmd_q regardless, this only flags the protocol breach.
    cmd_held_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_q != S_RUN) |-> fe_be.fe_cmd_v_i);

endmodule

// File: tb/tb_bp_fe_be_endpoint.sv
// Scoreboard bench: stimulus pushes expected fe_queue entries and expected
// command completions; a monitor pops/compares on every dequeue and yumi.
module tb_bp_fe_be_endpoint;
    import bp_fe_pkg::*;

    localparam int VA = 39;
    localparam int IW = 32;
    localparam int MW = 40;
    localparam int QW = 3 + VA + IW + MW;
    localparam int CW = 3 + VA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_fe_be_endpoint_if #(.vaddr_width_p(VA), .instr_width_p(IW),
                           .branch_metadata_fwd_width_p(MW)) bus ();

    bp_fe_be_endpoint #(.vaddr_width_p(VA), .instr_width_p(IW),
                        .branch_metadata_fwd_width_p(MW), .fe_queue_els_p(4)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .fe_be     (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [QW-1:0] exp_q[$];
    logic [CW-1:0] exp_cmd_q[$];
    logic [QW-1:0] mon_e;
    logic [CW-1:0] mon_c;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [QW-1:0] exp_of(input logic [VA-1:0] pc, input logic exc,
                                             input logic [1:0] code);
        logic [IW-1:0] ins;
        logic [MW-1:0] md;
        ins = {pc[29:0], 2'b11};
        md  = {1'b0, pc};
        return {exc, code, pc, ins, md};
    endfunction

    task automatic offer(input logic [VA-1:0] pc, input logic exc, input logic [1:0] code);
        bus.fetch_v_i         = 1'b1;
        bus.fetch_exception_i = exc;
        bus.fetch_exc_code_i  = code;
        bus.fetch_pc_i        = pc;
        bus.fetch_instr_i     = {pc[29:0], 2'b11};
        bus.fetch_metadata_i  = {1'b0, pc};
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [VA-1:0] npc);
        bus.fe_cmd_v_i = 1'b1;
        bus.fe_cmd_i   = {op, npc};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fe_queue transfer and every yumi is checked in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fe_queue_v_o && bus.fe_queue_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_deq: got %h expected none", bus.fe_queue_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("deq_entry", bus.fe_queue_o, mon_e);
                end
            end
            if (bus.fe_cmd_yumi_o) begin
                if (exp_cmd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_yumi: got op %0d npc %h expected none",
                             bus.redirect_opcode_o, bus.redirect_npc_o);
                end else begin
                    mon_c = exp_cmd_q.pop_front();
                    chk("yumi_cmd", {bus.redirect_opcode_o, bus.redirect_npc_o}, mon_c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.fetch_v_i = 0; bus.fetch_exception_i = 0; bus.fetch_exc_code_i = 0;
        bus.fetch_pc_i = 0; bus.fetch_instr_i = 0; bus.fetch_metadata_i = 0;
        bus.fe_queue_ready_i = 0; bus.fe_cmd_i = 0; bus.fe_cmd_v_i = 0;
        bus.redirect_ready_i = 0; bus.fence_done_i = 0;

        // Reset values before any clock edge.
        #2;
        chk("rst_queue_v", bus.fe_queue_v_o, 0);
        chk("rst_fetch_ready", bus.fetch_ready_o, 0);
        chk("rst_yumi", bus.fe_cmd_yumi_o, 0);
        chk("rst_redirect_v", bus.redirect_v_o, 0);
        chk("rst_npc", bus.redirect_npc_o, 0);
        #10 rst_n = 1'b1;
        step();

        // 1. Stream three PCs.
        chk("idle_ready", bus.fetch_ready_o, 1);
        bus.fe_queue_ready_i = 1;
        offer(39'h1000, 0, 0); exp_q.push_back(exp_of(39'h1000, 0, 0));
        #1 chk("no_bypass", bus.fe_queue_v_o, 0);
        step();
        chk("enq_latency", bus.fe_queue_v_o, 1);
        offer(39'h1004, 0, 0); exp_q.push_back(exp_of(39'h1004, 0, 0)); step();
        offer(39'h1008, 0, 0); exp_q.push_back(exp_of(39'h1008, 0, 0)); step();
        bus.fetch_v_i = 0;
        step(); step();
        chk("stream_drained", bus.fe_queue_v_o, 0);

        // 2. Fill to full, then drain.
        bus.fe_queue_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", bus.fetch_ready_o, 1);
            offer(39'h2000 + 39'(4 * i), 0, 0);
            exp_q.push_back(exp_of(39'h2000 + 39'(4 * i), 0, 0));
            step();
        end
        offer(39'h2010, 0, 0);
        #1 chk("full_ready", bus.fetch_ready_o, 0);
        bus.fe_queue_ready_i = 1;
        #1 chk("full_deq_no_bypass", bus.fetch_ready_o, 0);
        step();
        chk("ready_reasserts", bus.fetch_ready_o, 1);
        exp_q.push_back(exp_of(39'h2010, 0, 0));
        step();
        bus.fetch_v_i = 0;
        repeat (5) step();
        chk("fill_drained", bus.fe_queue_v_o, 0);

        // 3. Redirect with 3 queued; the head leaves in the command cycle.
        bus.fe_queue_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            offer(39'h3000 + 39'(4 * i), 0, 0);
            step();
        end
        bus.fetch_v_i = 0;
        exp_q.push_back(exp_of(39'h3000, 0, 0));
        bus.fe_queue_ready_i = 1;
        bus.redirect_ready_i = 1;
        send_cmd(3'd1, 39'h8000_0000);
        exp_cmd_q.push_back({3'd1, 39'h8000_0000});
        #1 chk("cmd_blocks_fetch", bus.fetch_ready_o, 0);
        step();
        chk("redir_v", bus.redirect_v_o, 1);
        chk("redir_npc", bus.redirect_npc_o, 39'h8000_0000);
        chk("redir_flushed", bus.fe_queue_v_o, 0);
        chk("redir_yumi", bus.fe_cmd_yumi_o, 1);
        step();
        bus.fe_cmd_v_i = 0;
        chk("redir_done_rv", bus.redirect_v_o, 0);
        offer(39'h8000_0000, 0, 0); exp_q.push_back(exp_of(39'h8000_0000, 0, 0));
        step();
        bus.fetch_v_i = 0;
        chk("new_head_v", bus.fe_queue_v_o, 1);
        step();

        // 4. Stray fence_done ignored; then icache fence.
        bus.fence_done_i = 1;
        #1 chk("stray_fence_yumi", bus.fe_cmd_yumi_o, 0);
        step();
        bus.fence_done_i = 0;
        send_cmd(3'd2, 39'h2000);
        step();
        chk("fence_redir_v", bus.redirect_v_o, 1);
        chk("fence_no_early_yumi", bus.fe_cmd_yumi_o, 0);
        step();
        offer(39'h5000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fence_ready", bus.fetch_ready_o, 0);
            chk("fence_yumi_wait", bus.fe_cmd_yumi_o, 0);
            chk("fence_rv", bus.redirect_v_o, 0);
            step();
        end
        bus.fence_done_i = 1;
        exp_cmd_q.push_back({3'd2, 39'h2000});
        #1 chk("fence_yumi", bus.fe_cmd_yumi_o, 1);
        chk("fence_ready_end", bus.fetch_ready_o, 0);
        step();
        bus.fence_done_i = 0; bus.fe_cmd_v_i = 0; bus.fetch_v_i = 0;
        step();

        // 5. Async reset while in e_fence.
        bus.fe_queue_ready_i = 0;
        offer(39'h9000, 0, 0); step();
        offer(39'h9004, 0, 0); step();
        bus.fetch_v_i = 0;
        send_cmd(3'd3, 39'h4000);
        step(); step();
        chk("itlb_in_fence", bus.redirect_v_o, 0);
        #2 rst_n = 1'b0;
        bus.fence_done_i = 1;
        #1;
        chk("arst_queue_v", bus.fe_queue_v_o, 0);
        chk("arst_fetch_ready", bus.fetch_ready_o, 0);
        chk("arst_yumi", bus.fe_cmd_yumi_o, 0);
        chk("arst_npc", bus.redirect_npc_o, 0);
        chk("arst_op", bus.redirect_opcode_o, 0);
        step();
        bus.fe_cmd_v_i = 0; bus.fence_done_i = 0; bus.redirect_ready_i = 0;
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_ready", bus.fetch_ready_o, 1);
        chk("post_rst_empty", bus.fe_queue_v_o, 0);
        chk("post_rst_rv", bus.redirect_v_o, 0);
        bus.fe_queue_ready_i = 1;
        step();
        bus.fe_queue_ready_i = 0;

        // 6. Reserved opcode, flushed exception entry, then back-to-back cmds.
        bus.redirect_ready_i = 1;
        send_cmd(3'd6, 39'h6000);
        exp_cmd_q.push_back({3'd6, 39'h6000});
        step();
        chk("rsvd_rv", bus.redirect_v_o, 1);
        chk("rsvd_op", bus.redirect_opcode_o, 6);
        chk("rsvd_yumi", bus.fe_cmd_yumi_o, 1);
        step();
        bus.fe_cmd_v_i = 0;
        offer(39'h6100, 1, 2'd2);
        step();
        bus.fetch_v_i = 0;
        send_cmd(3'd1, 39'h7000);
        exp_cmd_q.push_back({3'd1, 39'h7000});
        #1 chk("exc_queued", bus.fe_queue_v_o, 1);
        step();
        chk("exc_flushed", bus.fe_queue_v_o, 0);
        chk("redir2_yumi", bus.fe_cmd_yumi_o, 1);
        step();
        send_cmd(3'd0, 39'h100);
        exp_cmd_q.push_back({3'd0, 39'h100});
        step();
        chk("b2b_rv", bus.redirect_v_o, 1);
        chk("b2b_npc", bus.redirect_npc_o, 39'h100);
        chk("b2b_yumi", bus.fe_cmd_yumi_o, 1);
        step();
        bus.fe_cmd_v_i = 0; bus.redirect_ready_i = 0;
        bus.fe_queue_ready_i = 1;
        repeat (3) step();

        chk("sb_entries_left", exp_q.size(), 0);
        chk("sb_cmds_left", exp_cmd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
